// File: rtl/gray_counter_sync_if.sv
// gray_counter_sync_if
//   Bundles the counter controls, counter views and the remote Gray pointer
//   path of gray_counter_sync.
//   master : drives en/up/load/load_val/gray_in and observes the results
//   slave  : the pointer block itself
//   N      : counter / pointer width in bits
interface gray_counter_sync_if #(
    parameter int unsigned N = 5
);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] bin_out;
    logic [N-1:0] gray_out;
    logic         wrap;
    logic [N-1:0] gray_in;
    logic [N-1:0] dec_bin;
    logic         dec_chg;
    logic         step_err;

    modport master (
        output en, up, load, load_val, gray_in,
        input  bin_out, gray_out, wrap, dec_bin, dec_chg, step_err
    );

    modport slave (
        input  en, up, load, load_val, gray_in,
        output bin_out, gray_out, wrap, dec_bin, dec_chg, step_err
    );
endinterface

// File: rtl/gray_counter_sync.sv
// gray_counter_sync
//   Gray-code pointer block for the readout path.
//   Local side : registered up/down binary counter with synchronous load;
//                binary and Gray views are both registers updated together.
//   Remote side: SYNC_STAGES-deep synchroniser for a foreign Gray pointer,
//                registered Gray->binary decode, change and step-error pulses.
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous, active-high; clears every register
//   bus      : slave modport of gray_counter_sync_if
//              en, up, load, load_val        -> counter controls
//              bin_out, gray_out, wrap       <- counter views / wrap pulse
//              gray_in                       -> asynchronous foreign pointer
//              dec_bin, dec_chg, step_err    <- decoded pointer and flags
module gray_counter_sync #(
    parameter int unsigned N           = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gray_counter_sync_if.slave    bus
);

    localparam logic [N-1:0] ONE = N'(1);

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int unsigned i = 1; i < N; i++) begin
            b[N-1-i] = b[N-i] ^ g[N-1-i];
        end
        return b;
    endfunction

    // ---------------- local counter ----------------
    logic [N-1:0] bin_q,  bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == '1);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end
        // Gray view is registered from the next binary value so gray_out
        // never passes through combinational logic on its way to another domain.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    // ---------------- remote pointer path ----------------
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];
    logic [N-1:0] sl_prev_q, sl_prev_d;
    logic [N-1:0] dec_bin_q, dec_bin_d;
    logic         dec_chg_q, dec_chg_d;
    logic         step_err_q, step_err_d;
    logic [N-1:0] sl;
    logic [N-1:0] diff;

    always_comb begin
        sync_d[0] = bus.gray_in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        sl         = sync_q[SYNC_STAGES-1];
        diff       = sl ^ sl_prev_q;
        sl_prev_d  = sl;
        dec_bin_d  = g2b(sl);
        dec_chg_d  = (diff != '0);
        // More than one bit set <=> clearing the lowest set bit leaves something.
        step_err_d = ((diff & (diff - ONE)) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '{default: '0};
            sl_prev_q  <= '0;
            dec_bin_q  <= '0;
            dec_chg_q  <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sl_prev_q  <= sl_prev_d;
            dec_bin_q  <= dec_bin_d;
            dec_chg_q  <= dec_chg_d;
            step_err_q <= step_err_d;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;
    assign bus.dec_bin  = dec_bin_q;
    assign bus.dec_chg  = dec_chg_q;
    assign bus.step_err = step_err_q;

endmodule

// File: tb/tb_gray_counter_sync.sv
// tb_gray_counter_sync
//   Directed bench for gray_counter_sync with N=5, SYNC_STAGES=2.
module tb_gray_counter_sync;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic loopback;
    logic [4:0] hist [64];
    logic [4:0] prev_gray;
    logic [4:0] exp_bin;

    gray_counter_sync_if #(.N(5)) bus ();

    gray_counter_sync #(.N(5), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs sampled 1 time unit later, then the loopback
    // (if enabled) copies gray_out onto gray_in before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (loopback) bus.gray_in = bus.gray_out;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        loopback = 1'b0;
        reset    = 1'b1;
        bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0;
        bus.load_val = '0; bus.gray_in = '0;

        // ---- reset state ----
        step(); step();
        chk("rst_bin",  bus.bin_out,  16'd0);
        chk("rst_gray", bus.gray_out, 16'd0);
        chk("rst_wrap", bus.wrap,     16'd0);
        chk("rst_dec",  bus.dec_bin,  16'd0);
        chk("rst_chg",  bus.dec_chg,  16'd0);
        chk("rst_err",  bus.step_err, 16'd0);

        // ---- 1: count up through a full wrap ----
        reset = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        prev_gray = 5'b00000;
        for (int i = 1; i <= 33; i++) begin
            step();
            exp_bin = 5'(i);
            chk($sformatf("up_bin%0d", i),  bus.bin_out,  16'(exp_bin));
            chk($sformatf("up_gray%0d", i), bus.gray_out, 16'(exp_bin ^ (exp_bin >> 1)));
            chk($sformatf("up_1bit%0d", i), 16'($countones(bus.gray_out ^ prev_gray)), 16'd1);
            chk($sformatf("up_wrap%0d", i), bus.wrap, (i == 32) ? 16'd1 : 16'd0);
            prev_gray = bus.gray_out;
        end
        chk("up_gray_16", 16'(5'd16 ^ (5'd16 >> 1)), 16'b11000);

        // ---- 2: down from reset wraps to 31 ----
        reset = 1'b1; step();
        reset = 1'b0; bus.en = 1'b1; bus.up = 1'b0;
        step();
        chk("dn_bin",  bus.bin_out,  16'd31);
        chk("dn_gray", bus.gray_out, 16'b10000);
        chk("dn_wrap", bus.wrap,     16'd1);
        bus.en = 1'b0;
        step();
        chk("hold_bin",  bus.bin_out, 16'd31);
        chk("hold_wrap", bus.wrap,    16'd0);

        // ---- 3: load priority and no wrap on load ----
        bus.load = 1'b1; bus.load_val = 5'd0; bus.en = 1'b1; bus.up = 1'b1;
        step();
        chk("ld0_bin",  bus.bin_out,  16'd0);
        chk("ld0_gray", bus.gray_out, 16'd0);
        chk("ld0_wrap", bus.wrap,     16'd0);
        bus.load_val = 5'd20;
        step();
        chk("ld20_bin",  bus.bin_out,  16'd20);
        chk("ld20_gray", bus.gray_out, 16'b11110);
        chk("ld20_wrap", bus.wrap,     16'd0);
        bus.load_val = 5'd31; bus.up = 1'b0;
        step();
        chk("ld31_bin",  bus.bin_out, 16'd31);
        chk("ld31_wrap", bus.wrap,    16'd0);
        bus.load = 1'b0;
        step();
        chk("dec30_bin",  bus.bin_out,  16'd30);
        chk("dec30_gray", bus.gray_out, 16'b10001);
        chk("dec30_wrap", bus.wrap,     16'd0);
        bus.load = 1'b1; bus.load_val = 5'd0;
        step();
        chk("ld0b_bin",  bus.bin_out, 16'd0);
        chk("ld0b_wrap", bus.wrap,    16'd0);
        bus.load = 1'b0; bus.en = 1'b0;

        // ---- 4: loopback gray_out -> gray_in ----
        reset = 1'b1; step();
        reset = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        loopback = 1'b1;
        hist[0] = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            step();
            hist[k] = bus.bin_out;
            if (k >= 4) begin
                chk($sformatf("lb_dec%0d", k), bus.dec_bin,  16'(hist[k-3]));
                chk($sformatf("lb_chg%0d", k), bus.dec_chg,  16'd1);
                chk($sformatf("lb_err%0d", k), bus.step_err, 16'd0);
            end
        end
        loopback = 1'b0; bus.en = 1'b0;

        // ---- 5: multi-bit step on gray_in ----
        reset = 1'b1; bus.gray_in = 5'b00000; step();
        reset = 1'b0; step(); step(); step();
        chk("s5_idle_chg", bus.dec_chg, 16'd0);
        bus.gray_in = 5'b00011;
        step(); step();
        chk("s5_early_chg", bus.dec_chg, 16'd0);
        chk("s5_early_dec", bus.dec_bin, 16'd0);
        step();
        chk("s5_dec", bus.dec_bin,  16'd2);
        chk("s5_chg", bus.dec_chg,  16'd1);
        chk("s5_err", bus.step_err, 16'd1);
        step();
        chk("s5_dec_hold", bus.dec_bin,  16'd2);
        chk("s5_chg_off",  bus.dec_chg,  16'd0);
        chk("s5_err_off",  bus.step_err, 16'd0);
        bus.gray_in = 5'b00010;
        step(); step(); step();
        chk("s5b_dec", bus.dec_bin,  16'd3);
        chk("s5b_chg", bus.dec_chg,  16'd1);
        chk("s5b_err", bus.step_err, 16'd0);

        // ---- 6: reset mid-count ----
        bus.gray_in = 5'b01010;
        bus.load = 1'b1; bus.load_val = 5'd10; bus.en = 1'b1; bus.up = 1'b1;
        step();
        bus.load = 1'b0;
        step(); step(); step();
        chk("s6_bin13", bus.bin_out, 16'd13);
        chk("s6_pre_dec", bus.dec_bin, 16'd12);
        reset = 1'b1;
        step();
        chk("s6_rst_bin",  bus.bin_out,  16'd0);
        chk("s6_rst_gray", bus.gray_out, 16'd0);
        chk("s6_rst_wrap", bus.wrap,     16'd0);
        chk("s6_rst_dec",  bus.dec_bin,  16'd0);
        chk("s6_rst_chg",  bus.dec_chg,  16'd0);
        chk("s6_rst_err",  bus.step_err, 16'd0);
        reset = 1'b0;
        step(); step();
        chk("s6_mid_dec", bus.dec_bin, 16'd0);
        step();
        chk("s6_dec", bus.dec_bin,  16'd12);
        chk("s6_chg", bus.dec_chg,  16'd1);
        chk("s6_err", bus.step_err, 16'd1);
        chk("s6_bin", bus.bin_out,  16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
